// File: rtl/apb_arbiter.sv
// apb_arbiter: round-robin sharing of one APB master port among NREQ requesters,
// with a PREADY timeout that forces an error completion on a hung slave.
module apb_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int TMO  = 16
) (
  input  logic               pclk,
  input  logic               preset,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    req_write_i,
  input  logic [NREQ*AW-1:0] req_addr_i,
  input  logic [NREQ*DW-1:0] req_wdata_i,
  output logic [NREQ-1:0]    done_o,
  output logic [DW-1:0]      rsp_rdata_o,
  output logic               rsp_err_o,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [AW-1:0]      paddr,
  output logic [DW-1:0]      pwdata,
  input  logic [DW-1:0]      prdata,
  input  logic               pready,
  input  logic               pslverr
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TMO + 2);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, win_q, win_d, pick;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0] pwdata_q, pwdata_d;
  logic          tmo_hit, fin;
  int            j;
  // Scan downward so the last hit written is the first set bit at or above the pointer.
  always_comb begin
    pick = ptr_q;
    j = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = (int'(ptr_q) + i) % NREQ;
      if (req_i[IW'(j)]) pick = IW'(j);
    end
  end
  assign tmo_hit     = (TMO != 0) && state_q == ACCESS && !pready && cnt_q == CW'(TMO - 1);
  assign fin         = state_q == ACCESS && (pready || tmo_hit);
  assign done_o      = fin ? (NREQ'(1) << win_q) : '0;
  assign rsp_err_o   = fin && (!pready || pslverr);
  assign rsp_rdata_o = (fin && pready && !pwrite_q) ? prdata : '0;
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    case (state_q)
      IDLE: if (|req_i) begin
        state_d  = SETUP;
        win_d    = pick;
        psel_d   = 1'b1;
        pwrite_d = req_write_i[pick];
        paddr_d  = req_addr_i[int'(pick)*AW +: AW];
        pwdata_d = req_wdata_i[int'(pick)*DW +: DW];
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: if (fin) begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        ptr_d     = win_q == IW'(NREQ - 1) ? '0 : win_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end
  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
endmodule
